addsub_pipe: RTL and testbench

Parametrised, pipelined two's-complement add/subtract unit; successor to the single-cycle 32-bit CLA adder/subtractor. The carry chain is cut into SEG-bit carry-lookahead segments, one per pipeline stage, so any WIDTH meets timing at the core clock. It has valid/ready handshakes on both sides and per-stage bubble collapsing. It sits between the EX operand muxes and the result bus, and is also used by the multi-cycle MUL/DIV sequencers.

---
 rtl/addsub_pkg.sv | 35 +++
 rtl/addsub_pipe_if.sv | 46 ++++
 rtl/addsub_pipe_cla_segment.sv | 56 +++++
 rtl/addsub_pipe.sv | 141 ++++++++++++++
 tb/tb_addsub_pipe.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addsub_pkg
// Description : Shared encodings, stage-count helper and default stage layout
//               for the pipelined add/subtract unit.
// Revision    : 1.0 - initial release
// ============================================================================
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SEG   = 16;
    localparam int GROUP     = 4;

    function automatic int stages(input int width, input int seg);
        return width / seg;
    endfunction

    // Segments are tiled by whole 4-bit lookahead groups.
    function automatic bit width_ok(input int width, input int seg);
        return (seg > 0) && (seg % GROUP == 0) && (width >= seg) && (width % seg == 0);
    endfunction

    typedef struct packed {
        logic [DEF_WIDTH-1:0] acc;
        logic [DEF_WIDTH-1:0] bx;
        logic                 cy;
        logic                 c_msb;
        logic                 op;
    } stage_t;

endpackage
`default_nettype wire

// File: rtl/addsub_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : addsub_pipe_if
// Description : Operand/result handshake bundle of addsub_pipe. Carries the
//               sat/sgn qualifiers when ADDSUB_PIPE_SAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface addsub_pipe_if
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op;
`ifdef ADDSUB_PIPE_SAT_EN
    logic             sat;
    logic             sgn;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] r;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             negative;

    modport master (
        output in_valid, a, b, op, out_ready,
`ifdef ADDSUB_PIPE_SAT_EN
        output sat, sgn,
`endif
        input  in_ready, out_valid, r, carry, overflow, zero, negative
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
`ifdef ADDSUB_PIPE_SAT_EN
        input  sat, sgn,
`endif
        output in_ready, out_valid, r, carry, overflow, zero, negative
    );
endinterface
`default_nettype wire

// File: rtl/addsub_pipe_cla_segment.sv
`default_nettype none
// ============================================================================
// Module      : cla_segment
// Description : Combinational SEG-bit carry-lookahead adder made of 4-bit
//               lookahead groups; also reports the carry into the MSB.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_segment
    import addsub_pkg::*;
#(
    parameter int SEG = DEF_SEG
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           c_msb
);
    localparam int GROUPS = SEG / GROUP;

    logic [SEG-1:0] w_g;
    logic [SEG-1:0] w_p;
    logic [SEG:0]   w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Full lookahead inside each group; group carries chain between groups.
    always_comb begin
        logic [3:0] w_gl;
        logic [3:0] w_pl;
        logic       w_ci;
        w_c  = '0;
        w_gl = '0;
        w_pl = '0;
        w_ci = cin;
        for (int j = 0; j < GROUPS; j++) begin
            w_gl = w_g[j*GROUP +: GROUP];
            w_pl = w_p[j*GROUP +: GROUP];
            w_c[j*GROUP]     = w_ci;
            w_c[j*GROUP + 1] = w_gl[0] | (w_pl[0] & w_ci);
            w_c[j*GROUP + 2] = w_gl[1] | (w_pl[1] & w_gl[0]) | (w_pl[1] & w_pl[0] & w_ci);
            w_c[j*GROUP + 3] = w_gl[2] | (w_pl[2] & w_gl[1]) | (w_pl[2] & w_pl[1] & w_gl[0])
                             | (w_pl[2] & w_pl[1] & w_pl[0] & w_ci);
            w_ci = w_gl[3] | (w_pl[3] & w_gl[2]) | (w_pl[3] & w_pl[2] & w_gl[1])
                 | (w_pl[3] & w_pl[2] & w_pl[1] & w_gl[0]) | ((&w_pl) & w_ci);
        end
        w_c[SEG] = w_ci;
    end

    assign sum   = w_p ^ w_c[SEG-1:0];
    assign cout  = w_c[SEG];
    assign c_msb = w_c[SEG-1];
endmodule
`default_nettype wire

// File: rtl/addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : addsub_pipe
// Description : Pipelined add/subtract, one SEG-bit lookahead segment per
//               stage, valid/ready on both sides with bubble collapsing.
//               Define ADDSUB_PIPE_SAT_EN for sat/sgn result clamping.
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG
) (
    input  logic         clk,
    input  logic         rst,
    addsub_pipe_if.slave bus
);
    localparam int STAGES = stages(WIDTH, SEG);
    localparam int LAST   = STAGES - 1;

    if (!width_ok(WIDTH, SEG)) begin : g_bad_cfg
        $error("addsub_pipe: WIDTH must be a multiple of SEG and SEG a multiple of 4");
    end

    // acc holds finished sum bits below the current segment and raw a above it.
    typedef struct packed {
        logic [WIDTH-1:0] acc;
        logic [WIDTH-1:0] bx;
        logic             cy;
        logic             c_msb;
        logic             op;
`ifdef ADDSUB_PIPE_SAT_EN
        logic             sat;
        logic             sgn;
`endif
    } pipe_stage_t;

    pipe_stage_t                r_stage [STAGES];
    pipe_stage_t                w_src   [STAGES];
    logic [STAGES-1:0]          r_v;
    logic [STAGES-1:0]          w_src_v;
    logic [STAGES-1:0]          w_load;
    logic [STAGES-1:0][SEG-1:0] w_sum;
    logic [STAGES-1:0]          w_cout;
    logic [STAGES-1:0]          w_cmsb;
    logic [WIDTH-1:0]           w_r;
    logic                       w_carry;
    logic                       w_ovf;

    always_comb begin
        w_src[0]       = '0;
        w_src[0].acc   = bus.a;
        w_src[0].bx    = bus.b ^ {WIDTH{bus.op}};
        w_src[0].cy    = bus.op;
        w_src[0].op    = bus.op;
`ifdef ADDSUB_PIPE_SAT_EN
        w_src[0].sat   = bus.sat;
        w_src[0].sgn   = bus.sgn;
`endif
        w_src_v[0]     = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            w_src[k]   = r_stage[k-1];
            w_src_v[k] = r_v[k-1];
        end
    end

    // A stage loads when empty or when its own contents move on downstream.
    always_comb begin
        w_load       = '0;
        w_load[LAST] = ~r_v[LAST] | bus.out_ready;
        for (int k = LAST - 1; k >= 0; k--) begin
            w_load[k] = ~r_v[k] | w_load[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cla_segment #(
            .SEG (SEG)
        ) u_cla (
            .a     (w_src[k].acc[k*SEG +: SEG]),
            .b     (w_src[k].bx[k*SEG +: SEG]),
            .cin   (w_src[k].cy),
            .sum   (w_sum[k]),
            .cout  (w_cout[k]),
            .c_msb (w_cmsb[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_load[k]) begin
                    r_v[k] <= w_src_v[k];
                    if (w_src_v[k]) begin
                        r_stage[k]                     <= w_src[k];
                        r_stage[k].acc[k*SEG +: SEG]   <= w_sum[k];
                        r_stage[k].cy                  <= w_cout[k];
                        r_stage[k].c_msb               <= w_cmsb[k];
                    end
                end
            end
        end
    end

    assign w_carry = r_stage[LAST].cy ^ r_stage[LAST].op;
    assign w_ovf   = r_stage[LAST].c_msb ^ r_stage[LAST].cy;

`ifdef ADDSUB_PIPE_SAT_EN
    // A wrapped MSB of 1 under signed overflow means the true result was positive.
    always_comb begin
        w_r = r_stage[LAST].acc;
        if (r_stage[LAST].sat) begin
            if (r_stage[LAST].sgn) begin
                if (w_ovf) begin
                    w_r = r_stage[LAST].acc[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                                     : {1'b1, {(WIDTH-1){1'b0}}};
                end
            end else if (w_carry) begin
                w_r = (r_stage[LAST].op == OP_ADD) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
            end
        end
    end
`else
    assign w_r = r_stage[LAST].acc;
`endif

    assign bus.in_ready  = w_load[0];
    assign bus.out_valid = r_v[LAST];
    assign bus.r         = w_r;
    assign bus.carry     = w_carry;
    assign bus.overflow  = w_ovf;
    assign bus.zero      = ~|r_stage[LAST].acc;
    assign bus.negative  = r_stage[LAST].acc[WIDTH-1];
endmodule
`default_nettype wire

// File: tb/tb_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_addsub_pipe
// Description : Directed and swept checks of addsub_pipe at (32,16), (64,16)
//               and (32,32); sat cases build only with ADDSUB_PIPE_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_pipe;
    logic clk;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    addsub_pipe_if #(.WIDTH(32)) bus32 ();
    addsub_pipe_if #(.WIDTH(64)) bus64 ();
    addsub_pipe_if #(.WIDTH(32)) bus1  ();

    addsub_pipe #(.WIDTH(32), .SEG(16)) u_dut   (.clk(clk), .rst(rst), .bus(bus32.slave));
    addsub_pipe #(.WIDTH(64), .SEG(16)) u_dut64 (.clk(clk), .rst(rst), .bus(bus64.slave));
    addsub_pipe #(.WIDTH(32), .SEG(32)) u_dut1  (.clk(clk), .rst(rst), .bus(bus1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns {carry, overflow, zero, negative, r}
    function automatic logic [67:0] model(input int w, input logic [63:0] a_in,
                                          input logic [63:0] b_in, input logic op);
        logic [63:0] mask, a, b, r;
        logic [64:0] s;
        logic        c, v, sa, sb, sr;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        a = a_in & mask;
        b = b_in & mask;
        if (op == 1'b0) begin
            s = {1'b0, a} + {1'b0, b};
            c = s[w];
        end else begin
            s = {1'b0, a} - {1'b0, b};
            c = (a < b);
        end
        r  = s[63:0] & mask;
        sa = a[w-1];
        sb = b[w-1];
        sr = r[w-1];
        v  = (op == 1'b0) ? ((sa == sb) && (sr != sa)) : ((sa != sb) && (sr != sa));
        return {c, v, (r == 64'd0), sr, r};
    endfunction

    task automatic drive(input int which, input logic v, input logic [63:0] a,
                         input logic [63:0] b, input logic op);
        case (which)
            0:       begin bus32.in_valid = v; bus32.a = a[31:0]; bus32.b = b[31:0]; bus32.op = op; end
            1:       begin bus64.in_valid = v; bus64.a = a;       bus64.b = b;       bus64.op = op; end
            default: begin bus1.in_valid  = v; bus1.a  = a[31:0]; bus1.b  = b[31:0]; bus1.op  = op; end
        endcase
    endtask

    function automatic logic get_ov(input int which);
        case (which)
            0:       return bus32.out_valid;
            1:       return bus64.out_valid;
            default: return bus1.out_valid;
        endcase
    endfunction

    function automatic logic get_ir(input int which);
        case (which)
            0:       return bus32.in_ready;
            1:       return bus64.in_ready;
            default: return bus1.in_ready;
        endcase
    endfunction

    function automatic logic [63:0] get_r(input int which);
        case (which)
            0:       return 64'(bus32.r);
            1:       return bus64.r;
            default: return 64'(bus1.r);
        endcase
    endfunction

    function automatic logic [3:0] get_flags(input int which);
        case (which)
            0:       return {bus32.carry, bus32.overflow, bus32.zero, bus32.negative};
            1:       return {bus64.carry, bus64.overflow, bus64.zero, bus64.negative};
            default: return {bus1.carry,  bus1.overflow,  bus1.zero,  bus1.negative};
        endcase
    endfunction

    // Single isolated beat: checks acceptance, latency, result and flags.
    task automatic beat(input string tag, input int which, input logic [63:0] a,
                        input logic [63:0] b, input logic op, input logic [67:0] exp,
                        input int exp_lat);
        int lat;
        drive(which, 1'b1, a, b, op);
        #1;
        chk({tag, ".in_ready"}, 64'(get_ir(which)), 64'd1);
        tick();
        drive(which, 1'b0, a, b, op);
        lat = 1;
        while (!get_ov(which) && lat < 8) begin
            tick();
            lat++;
        end
        chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, ".r"}, get_r(which), exp[63:0]);
        chk({tag, ".flags"}, 64'(get_flags(which)), 64'(exp[67:64]));
        tick();
    endtask

    logic [31:0] bp_a   [4];
    logic [31:0] bp_b   [4];
    logic        bp_op  [4];
    logic [31:0] bp_exp [4];

    initial begin
        int acc, got, cyc;
        logic rdy, ov;
        logic [63:0] ra, rb;
        logic        rop;
        int          w, lat;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 64'd0, 64'd0, 1'b0);
        bus32.out_ready = 1'b1;
        bus64.out_ready = 1'b1;
        bus1.out_ready  = 1'b1;
`ifdef ADDSUB_PIPE_SAT_EN
        bus32.sat = 1'b0; bus32.sgn = 1'b0;
        bus64.sat = 1'b0; bus64.sgn = 1'b0;
        bus1.sat  = 1'b0; bus1.sgn  = 1'b0;
`endif
        tick();
        tick();
        chk("reset.out_valid", 64'(bus32.out_valid), 64'd0);
        chk("reset.r", 64'(bus32.r), 64'd0);
        chk("reset.flags", 64'(get_flags(0)), 64'(4'b0010));
        rst = 1'b0;
        #1;
        chk("reset.in_ready", 64'(bus32.in_ready), 64'd1);

        // Directed vectors on the 32/16 unit; flags are {carry,ovf,zero,neg}
        beat("add_xstage", 0, 64'h0000FFFF, 64'h1, 1'b0, {4'b0000, 64'h00010000}, 2);
        beat("sub_borrow", 0, 64'h3, 64'h5, 1'b1, {4'b1001, 64'hFFFFFFFE}, 2);
        beat("add_ovf", 0, 64'h7FFFFFFF, 64'h1, 1'b0, {4'b0101, 64'h80000000}, 2);
        beat("add_wrap", 0, 64'hFFFFFFFF, 64'h1, 1'b0, {4'b1010, 64'h0}, 2);
        beat("sub_equal", 0, 64'h5, 64'h5, 1'b1, {4'b0010, 64'h0}, 2);
        beat("sub_ovf", 0, 64'h80000000, 64'h1, 1'b1, {4'b0100, 64'h7FFFFFFF}, 2);
`ifdef ADDSUB_PIPE_SAT_EN
        bus32.sat = 1'b1; bus32.sgn = 1'b1;
        beat("sat_sgn_pos", 0, 64'h7FFFFFFF, 64'h1, 1'b0, {4'b0101, 64'h7FFFFFFF}, 2);
        beat("sat_sgn_neg", 0, 64'h80000000, 64'h1, 1'b1, {4'b0100, 64'h80000000}, 2);
        bus32.sgn = 1'b0;
        beat("sat_uns_add", 0, 64'hFFFFFFFF, 64'h2, 1'b0, {4'b1000, 64'hFFFFFFFF}, 2);
        beat("sat_uns_sub", 0, 64'h3, 64'h5, 1'b1, {4'b1001, 64'h0}, 2);
        bus32.sat = 1'b0;
`endif

        // Backpressure: four beats against a stalled consumer
        bp_a[0] = 32'h1;   bp_b[0] = 32'h2;   bp_op[0] = 1'b0; bp_exp[0] = 32'h3;
        bp_a[1] = 32'hA;   bp_b[1] = 32'h3;   bp_op[1] = 1'b1; bp_exp[1] = 32'h7;
        bp_a[2] = 32'h100; bp_b[2] = 32'h200; bp_op[2] = 1'b0; bp_exp[2] = 32'h300;
        bp_a[3] = 32'h0;   bp_b[3] = 32'h1;   bp_op[3] = 1'b1; bp_exp[3] = 32'hFFFFFFFF;
        bus32.out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            drive(0, 1'b1, 64'(bp_a[acc]), 64'(bp_b[acc]), bp_op[acc]);
            #1;
            rdy = bus32.in_ready;
            tick();
            if (rdy) acc++;
        end
        chk("bp.accepted", 64'(acc), 64'd2);
        chk("bp.in_ready_low", 64'(bus32.in_ready), 64'd0);
        chk("bp.stall_valid", 64'(bus32.out_valid), 64'd1);
        chk("bp.stall_r", 64'(bus32.r), 64'(bp_exp[0]));
        bus32.out_ready = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 4 && cyc < 10) begin
            drive(0, (acc < 4), 64'(bp_a[acc % 4]), 64'(bp_b[acc % 4]), bp_op[acc % 4]);
            #1;
            rdy = bus32.in_ready;
            ov  = bus32.out_valid;
            if (ov) begin
                chk($sformatf("bp.out%0d", got), 64'(bus32.r), 64'(bp_exp[got]));
                got++;
            end
            tick();
            cyc++;
            if (rdy && acc < 4) acc++;
        end
        drive(0, 1'b0, 64'd0, 64'd0, 1'b0);
        chk("bp.drain_cycles", 64'(cyc), 64'd4);
        chk("bp.no_dup", 64'(bus32.out_valid), 64'd0);

        // Reset with two beats in flight
        bus32.out_ready = 1'b0;
        drive(0, 1'b1, 64'h1234, 64'h1, 1'b0);
        tick();
        drive(0, 1'b1, 64'hFFFF, 64'hFFFF, 1'b0);
        tick();
        drive(0, 1'b0, 64'd0, 64'd0, 1'b0);
        chk("rstmid.full", 64'(bus32.out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("rstmid.out_valid", 64'(bus32.out_valid), 64'd0);
        chk("rstmid.r", 64'(bus32.r), 64'd0);
        chk("rstmid.flags", 64'(get_flags(0)), 64'(4'b0010));
        tick();
        rst = 1'b0;
        #1;
        chk("rstmid.in_ready", 64'(bus32.in_ready), 64'd1);
        bus32.out_ready = 1'b1;
        beat("rstmid.next", 0, 64'h12345678, 64'h11111111, 1'b0, {4'b0000, 64'h23456789}, 2);

        // Boundary and random sweep against the reference model
        beat("w64.xseg", 1, 64'h00000000FFFFFFFF, 64'h1, 1'b0,
             model(64, 64'h00000000FFFFFFFF, 64'h1, 1'b0), 4);
        beat("w64.wrap", 1, 64'hFFFFFFFFFFFFFFFF, 64'h1, 1'b0,
             model(64, 64'hFFFFFFFFFFFFFFFF, 64'h1, 1'b0), 4);
        beat("w32s1.borrow", 2, 64'h3, 64'h5, 1'b1, model(32, 64'h3, 64'h5, 1'b1), 1);
        for (int which = 0; which < 3; which++) begin
            w   = (which == 1) ? 64 : 32;
            lat = (which == 1) ? 4 : ((which == 2) ? 1 : 2);
            for (int i = 0; i < 6; i++) begin
                ra  = {$urandom, $urandom};
                rb  = {$urandom, $urandom};
                rop = 1'($urandom_range(1, 0));
                if (w == 32) begin
                    ra[63:32] = '0;
                    rb[63:32] = '0;
                end
                beat($sformatf("sweep%0d.%0d", which, i), which, ra, rb, rop,
                     model(w, ra, rb, rop), lat);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
